updown_mod_counter: RTL
=======================

Name: updown_mod_counter

Overview:
- Parametrised successor to the fixed 12-bit free-running up counter.
- Counts up or down modulo MOD_VAL. Supports an enable, a synchronous parallel load, an optional prescaler, and wrap or saturate mode.
- Produces a carry/borrow pulse, a sticky overflow flag and boundary flags.
- Used as the timebase and event counter feeding the binary-to-BCD and display-driver path.

Parameters:
- WIDTH, 12: count register width in bits.
- MOD_VAL, 4096: count range is 0..MOD_VAL-1. Must satisfy 2 <= MOD_VAL <= 2**WIDTH.
- PRESCALE, 1: number of enabled cycles per count step. Must be >= 1; 1 means step every enabled cycle.
- SATURATE, 0: 0 = wrap at the boundaries; 1 = hold at the boundaries.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: count enable (advances the prescaler).
- up_dn, input, 1: 1 = count up, 0 = count down. Sampled on each step.
- load, input, 1: synchronous parallel load.
- load_val, input, WIDTH: value to load.
- clr_ovf, input, 1: clears the sticky overflow flag.
- count, output, WIDTH: current count (registered).
- carry, output, 1: one-cycle registered pulse on a wrap in either direction.
- ovf, output, 1: sticky flag, set on any wrap or saturation attempt.
- at_max, output, 1: combinational; asserted when count == MOD_VAL-1.
- at_zero, output, 1: combinational; asserted when count == 0.

Behaviour:
- Reset: rst=1 at a rising edge sets count=0, carry=0, ovf=0 and clears the internal prescaler. rst has priority over every other input.
- Priority order each edge: rst > load > step.
- Load:
  - count <= load_val when load_val <= MOD_VAL-1; otherwise count <= MOD_VAL-1 (clamp).
  - The prescaler is cleared, carry=0 that cycle, and ovf is unaffected.
  - en is ignored in a load cycle.
- Prescaler:
  - Internal counter pre_cnt runs 0..PRESCALE-1 and advances only when en=1 and load=0.
  - A step occurs on the edge where en=1 and pre_cnt==PRESCALE-1; pre_cnt then returns to 0.
  - With PRESCALE=1 a step occurs on every enabled edge.
  - en=0 freezes both pre_cnt and count.
- Step up:
  - If count < MOD_VAL-1: count+1.
  - At MOD_VAL-1 with SATURATE=0: count <= 0, carry=1, ovf set.
  - At MOD_VAL-1 with SATURATE=1: count holds, carry=0, ovf set.
- Step down:
  - If count > 0: count-1.
  - At 0 with SATURATE=0: count <= MOD_VAL-1, carry=1, ovf set.
  - At 0 with SATURATE=1: count holds, carry=0, ovf set.
- Latency and carry timing:
  - count updates on the same edge as the step (registered output).
  - carry is registered and high for exactly the one cycle in which count shows the wrapped value; it is 0 on every other cycle.
- Direction change: a change of up_dn takes effect on the next step; the prescaler phase is not reset.
- Overflow flag:
  - clr_ovf=1 clears ovf on the next edge.
  - If clr_ovf coincides with a new wrap or saturation, ovf=1 (set wins).
- Reset mid-count: rst overrides a pending step or load on that edge; counting resumes from 0 with a fresh prescaler phase once rst=0.
- Arithmetic is WIDTH bits, with no intermediate overflow. The MOD_VAL-1 compare uses a WIDTH-bit constant.

Test Plan:
- Reset and wrap (defaults): pulse rst for 1 cycle, then en=1, up_dn=1 for 4096 clocks -> count goes 0..4095 then 0; carry=1 for exactly 1 cycle on the 0 after 4095; ovf=1; at_max high only while count==4095.
- Down wrap: load 0, then en=1, up_dn=0 for 1 clock -> count=4095, carry=1, at_max=1. The next clock gives 4094 with carry=0.
- Load clamp and priority (MOD_VAL=10, WIDTH=4):
  - load=1, load_val=13 with en=1 -> count=9, no carry.
  - Next up step -> 0 with carry=1.
- Prescaler (PRESCALE=4): en=1 for 12 clocks from reset -> count=3. Deasserting en for 5 clocks mid-phase -> count and phase frozen; after re-enable the step occurs after the remaining phase cycles.
- Saturate (SATURATE=1, MOD_VAL=10):
  - Up from 8 for 3 steps -> 9, 9, 9; carry always 0; ovf=1.
  - clr_ovf together with a further saturating step -> ovf stays 1.
  - clr_ovf alone -> ovf=0.
- Reset mid-operation: count=1234, assert rst together with load=1 and en=1 -> count=0, ovf=0, carry=0. After release the first step lands after PRESCALE enabled cycles.

Source files
------------

// File: rtl/updown_mod_counter.sv
// ============================================================================
// Module   : updown_mod_counter
// Purpose  : Up/down modulo-MOD_VAL counter with load, prescaler, wrap or
//            saturate mode, carry pulse, sticky overflow and boundary flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module updown_mod_counter #(
   parameter int WIDTH    = 12,
   parameter int MOD_VAL  = 4096,
   parameter int PRESCALE = 1,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] count,
   output logic             carry,
   output logic             ovf,
   output logic             at_max,
   output logic             at_zero
);

   localparam logic [WIDTH-1:0] c_max = WIDTH'(MOD_VAL - 1);
   localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

   logic [WIDTH-1:0] r_count;
   logic             r_carry;
   logic             r_ovf;

   logic             w_tick;
   logic             w_at_max;
   logic             w_at_zero;
   logic [WIDTH-1:0] w_clamped;
   logic [WIDTH-1:0] w_next_count;
   logic             w_wrap;
   logic             w_hit;

   // Prescaler: w_tick marks the enabled cycle on which the count steps.
   generate
      if (PRESCALE > 1) begin : g_prescale
         localparam int             c_pw       = $clog2(PRESCALE);
         localparam logic [c_pw-1:0] c_pre_last = c_pw'(PRESCALE - 1);
         localparam logic [c_pw-1:0] c_pre_one  = c_pw'(1);

         logic [c_pw-1:0] r_pre_cnt;

         always_ff @(posedge clk) begin
            if (rst || load) begin
               r_pre_cnt <= '0;
            end else if (en) begin
               r_pre_cnt <= (r_pre_cnt == c_pre_last) ? '0 : r_pre_cnt + c_pre_one;
            end
         end

         assign w_tick = en && (r_pre_cnt == c_pre_last);
      end else begin : g_no_prescale
         assign w_tick = en;
      end
   endgenerate

   assign w_at_max  = (r_count == c_max);
   assign w_at_zero = (r_count == '0);
   assign w_clamped = (load_val > c_max) ? c_max : load_val;

   always_comb begin
      w_next_count = r_count;
      w_wrap       = 1'b0;
      w_hit        = 1'b0;
      if (up_dn) begin
         if (w_at_max) begin
            w_hit = 1'b1;
            if (SATURATE == 0) begin
               w_next_count = '0;
               w_wrap       = 1'b1;
            end
         end else begin
            w_next_count = r_count + c_one;
         end
      end else begin
         if (w_at_zero) begin
            w_hit = 1'b1;
            if (SATURATE == 0) begin
               w_next_count = c_max;
               w_wrap       = 1'b1;
            end
         end else begin
            w_next_count = r_count - c_one;
         end
      end
   end

   // A boundary hit in the same cycle as clr_ovf keeps the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_carry <= 1'b0;
         if (clr_ovf) begin
            r_ovf <= 1'b0;
         end
         if (load) begin
            r_count <= w_clamped;
         end else if (w_tick) begin
            r_count <= w_next_count;
            r_carry <= w_wrap;
            if (w_hit) begin
               r_ovf <= 1'b1;
            end
         end
      end
   end

   assign count   = r_count;
   assign carry   = r_carry;
   assign ovf     = r_ovf;
   assign at_max  = w_at_max;
   assign at_zero = w_at_zero;

endmodule

`default_nettype wire
